// File: rtl/boot_loader.sv
// boot_loader: streams a boot image into IM/DM over valid/ready and holds the CPU in reset until done.
// Optional macro BOOT_CHECKSUM_EN: the final beat is a checksum of the written words; a mismatch parks in ERR.
module boot_loader #(
    parameter int DATA_W   = 32,
    parameter int IM_AW    = 10,
    parameter int DM_AW    = 10,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_last,
    input  logic              reload,
    output logic              im_we,
    output logic [IM_AW-1:0]  im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              err
);

    // state  | meaning
    // S_IDLE | one cycle after reset before loading starts
    // S_LOAD | accepting stream beats
    // S_HOLD | last beat taken, core kept in reset for HOLD_CYC+1 cycles
    // S_RUN  | core released, load_done high
    // S_ERR  | checksum mismatch, core kept in reset until reload

    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3
`ifdef BOOT_CHECKSUM_EN
        , S_ERR = 3'd4
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [IM_AW:0]  im_cnt;
    logic [DM_AW:0]  dm_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            accept, data_beat, im_wr, dm_wr, ovf, bad_sum, clr;

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    assign in_ready = (state == S_LOAD);

    always_comb begin
        accept = in_valid && (state == S_LOAD);
`ifdef BOOT_CHECKSUM_EN
        data_beat = accept && !in_last;
        bad_sum   = accept && in_last && (in_data != sum);
        clr       = reload && ((state == S_RUN) || (state == S_ERR));
`else
        data_beat = accept;
        bad_sum   = 1'b0;
        clr       = reload && (state == S_RUN);
`endif
        // counters saturate at DEPTH, so the top bit alone marks a full memory
        im_wr = data_beat && !in_sel && !im_cnt[IM_AW];
        dm_wr = data_beat &&  in_sel && !dm_cnt[DM_AW];
        ovf   = data_beat && (in_sel ? dm_cnt[DM_AW] : im_cnt[IM_AW]);

        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_LOAD;
            S_LOAD: begin
                if (accept && in_last) state_nxt = S_HOLD;
`ifdef BOOT_CHECKSUM_EN
                if (bad_sum) state_nxt = S_ERR;
`endif
            end
            S_HOLD: if (hold_cnt == '0) state_nxt = S_RUN;
            default: if (clr) state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            err       <= 1'b0;
            im_cnt    <= '0;
            dm_cnt    <= '0;
            hold_cnt  <= '0;
        end else begin
            cpu_rst   <= (state_nxt != S_RUN);
            load_done <= (state_nxt == S_RUN);
            im_we     <= im_wr;
            dm_we     <= dm_wr;
            if (im_wr) begin
                im_addr  <= im_cnt[IM_AW-1:0];
                im_wdata <= in_data;
            end
            if (dm_wr) begin
                dm_addr  <= dm_cnt[DM_AW-1:0];
                dm_wdata <= in_data;
            end
            if (clr) begin
                im_cnt <= '0;
                dm_cnt <= '0;
                err    <= 1'b0;
            end else begin
                if (im_wr) im_cnt <= im_cnt + (IM_AW+1)'(1);
                if (dm_wr) dm_cnt <= dm_cnt + (DM_AW+1)'(1);
                if (ovf || bad_sum) err <= 1'b1;
            end
            if (state != S_HOLD && state_nxt == S_HOLD) hold_cnt <= HW'(HOLD_CYC);
            else if (state == S_HOLD && hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 sum <= '0;
        else if (clr)            sum <= '0;
        else if (im_wr || dm_wr) sum <= sum + in_data;
    end
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: phase-level reference model checked every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_boot_loader;
    localparam int DATA_W   = 32;
    localparam int IM_AW    = 2;
    localparam int DM_AW    = 3;
    localparam int HOLD_CYC = 4;
    localparam int IM_DEPTH = 1 << IM_AW;
    localparam int DM_DEPTH = 1 << DM_AW;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_ERR = 4;

    logic              clk = 1'b0, rst = 1'b1;
    logic              in_valid = 1'b0, in_sel = 1'b0, in_last = 1'b0, reload = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, im_we, dm_we, cpu_rst, load_done, err;
    logic [IM_AW-1:0]  im_addr;
    logic [DM_AW-1:0]  dm_addr;
    logic [DATA_W-1:0] im_wdata, dm_wdata;

    int n_checks = 0, n_pass = 0;
    logic [DATA_W-1:0] im_mem [IM_DEPTH];
    logic [DATA_W-1:0] dm_mem [DM_DEPTH];
    int im_wr_cnt = 0;

    // reference model state
    int ph = P_IDLE, hold_left = 0, im_n = 0, dm_n = 0;
    logic m_err = 1'b0;
    logic [DATA_W-1:0] m_sum = '0;
    logic e_im_we = 1'b0, e_dm_we = 1'b0, ckb;
    logic [IM_AW-1:0]  e_im_addr = '0;
    logic [DM_AW-1:0]  e_dm_addr = '0;
    logic [DATA_W-1:0] e_im_wdata = '0, e_dm_wdata = '0;

    always #5 clk = ~clk;

    boot_loader #(.DATA_W(DATA_W), .IM_AW(IM_AW), .DM_AW(DM_AW), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last), .reload(reload),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // compare, capture writes, then advance the model by the coming edge
    always @(negedge clk) begin
        if (rst) begin
            ph = P_IDLE; hold_left = 0; im_n = 0; dm_n = 0; m_err = 1'b0; m_sum = '0;
            e_im_we = 1'b0; e_dm_we = 1'b0;
        end
        chk("in_ready", in_ready, ph == P_LOAD);
        chk("cpu_rst", cpu_rst, ph != P_RUN);
        chk("load_done", load_done, ph == P_RUN);
        chk("err", err, m_err);
        chk("im_we", im_we, e_im_we);
        chk("dm_we", dm_we, e_dm_we);
        if (e_im_we) begin
            chk("im_addr", im_addr, e_im_addr);
            chk("im_wdata", im_wdata, e_im_wdata);
        end
        if (e_dm_we) begin
            chk("dm_addr", dm_addr, e_dm_addr);
            chk("dm_wdata", dm_wdata, e_dm_wdata);
        end
        if (im_we) begin im_mem[im_addr] = im_wdata; im_wr_cnt++; end
        if (dm_we) dm_mem[dm_addr] = dm_wdata;

        if (!rst) begin
            e_im_we = 1'b0; e_dm_we = 1'b0;
            case (ph)
                P_IDLE: ph = P_LOAD;
                P_LOAD: if (in_valid) begin
                    ckb = CK && in_last;
                    if (!ckb && !in_sel) begin
                        if (im_n < IM_DEPTH) begin
                            e_im_we = 1'b1; e_im_addr = IM_AW'(im_n); e_im_wdata = in_data;
                            im_n++; m_sum = m_sum + in_data;
                        end else m_err = 1'b1;
                    end else if (!ckb) begin
                        if (dm_n < DM_DEPTH) begin
                            e_dm_we = 1'b1; e_dm_addr = DM_AW'(dm_n); e_dm_wdata = in_data;
                            dm_n++; m_sum = m_sum + in_data;
                        end else m_err = 1'b1;
                    end
                    if (in_last) begin
                        if (ckb && m_sum != in_data) begin ph = P_ERR; m_err = 1'b1; end
                        else begin ph = P_HOLD; hold_left = HOLD_CYC + 1; end
                    end
                end
                P_HOLD: begin
                    hold_left--;
                    if (hold_left == 0) ph = P_RUN;
                end
                default: if (reload) begin
                    ph = P_LOAD; im_n = 0; dm_n = 0; m_err = 1'b0; m_sum = '0;
                end
            endcase
        end
    end

    task automatic beat(input logic s, input logic [31:0] d, input logic l);
        int k = 0;
        in_valid = 1'b1; in_sel = s; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        chk("handshake_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic wait_run();
        int k = 0;
        while (!load_done && k < 50) begin @(posedge clk); #1; k++; end
        chk("reached_run", load_done, 1'b1);
    endtask

    initial begin
        int lat, n0;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_dm_wdata", dm_wdata, 0);
        rst = 1'b0;
`ifndef BOOT_CHECKSUM_EN
        // three IM beats, release latency
        beat(0, 32'h11, 0); beat(0, 32'h22, 0); beat(0, 32'h33, 1);
        lat = 0;
        while (cpu_rst && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("release_latency", lat, HOLD_CYC + 1);
        chk("t1_im0", im_mem[0], 32'h11);
        chk("t1_im1", im_mem[1], 32'h22);
        chk("t1_im2", im_mem[2], 32'h33);
        chk("t1_load_done", load_done, 1'b1);
        // interleaved IM/DM
        pulse_reload();
        chk("reload_cpu_rst", cpu_rst, 1'b1);
        beat(0, 32'hA, 0); beat(1, 32'hB, 0); beat(1, 32'hC, 0); beat(0, 32'hD, 1);
        wait_run();
        chk("t2_im0", im_mem[0], 32'hA);
        chk("t2_im1", im_mem[1], 32'hD);
        chk("t2_dm0", dm_mem[0], 32'hB);
        chk("t2_dm1", dm_mem[1], 32'hC);
        chk("t2_err", err, 1'b0);
        // gappy valid
        pulse_reload();
        for (int i = 1; i <= 6; i++) begin
            beat(1, 32'(i), i == 6);
            if (i < 6) idle(1);
        end
        wait_run();
        chk("t3_dm0", dm_mem[0], 32'd1);
        chk("t3_dm5", dm_mem[5], 32'd6);
        // IM overflow
        pulse_reload();
        n0 = im_wr_cnt;
        for (int i = 0; i < 5; i++) beat(0, 32'h100 + 32'(i), i == 4);
        wait_run();
        chk("t4_err", err, 1'b1);
        chk("t4_writes", im_wr_cnt - n0, 4);
        chk("t4_im0", im_mem[0], 32'h100);
        chk("t4_im3", im_mem[3], 32'h103);
        // reload clears err
        pulse_reload();
        chk("t5_reload_cpu_rst", cpu_rst, 1'b1);
        beat(0, 32'h55, 1);
        wait_run();
        chk("t5_im0", im_mem[0], 32'h55);
        chk("t5_err", err, 1'b0);
        // async reset on the write cycle after the last beat
        pulse_reload();
        beat(0, 32'h66, 1);
        rst = 1'b1; #1;
        chk("arst_im_we", im_we, 1'b0);
        chk("arst_dm_we", dm_we, 1'b0);
        chk("arst_cpu_rst", cpu_rst, 1'b1);
        chk("arst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_dropped", im_mem[0], 32'h55);
        // reload outside RUN/ERR is ignored
        reload = 1'b1;
        beat(0, 32'h77, 1);
        reload = 1'b0;
        wait_run();
        chk("t6_im0", im_mem[0], 32'h77);
`else
        // matching checksum
        n0 = im_wr_cnt;
        beat(0, 32'h1, 0); beat(0, 32'h2, 0); beat(0, 32'h3, 1);
        wait_run();
        chk("ck_writes", im_wr_cnt - n0, 2);
        chk("ck_im1", im_mem[1], 32'h2);
        chk("ck_err", err, 1'b0);
        // mismatching checksum
        pulse_reload();
        beat(0, 32'h1, 0); beat(0, 32'h2, 0); beat(0, 32'h4, 1);
        idle(12);
        chk("ckbad_err", err, 1'b1);
        chk("ckbad_cpu_rst", cpu_rst, 1'b1);
        chk("ckbad_load_done", load_done, 1'b0);
        chk("ckbad_in_ready", in_ready, 1'b0);
        pulse_reload();
        chk("ckbad_reload_err", err, 1'b0);
        beat(1, 32'h9, 0); beat(0, 32'h9, 1);
        wait_run();
        chk("ck_dm0", dm_mem[0], 32'h9);
`endif
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000ns");
        $fatal(1);
    end

endmodule
